// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver: majority-voted bit sampling, optional parity,
// 1 or 2 stop bits, break detection and a single-word valid/ready output holding register.
module uart_rx_ovs #(
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  rx_data_in,
    output logic [WORD_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic                  rx_break,
    output logic                  s_idle,
    output logic                  s_start,
    output logic                  s_data,
    output logic                  s_parity,
    output logic                  s_stop,
    output logic                  s_wait
);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT} state_t;

    localparam int TICK_DIV = CLK_RATE / (BAUD_RATE * 16);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0] LAST_BIT  = 4'(WORD_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY == 1);

    state_t                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic                    rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [3:0]              tick_cnt_q, tick_cnt_d;
    logic [1:0]              vote_q, vote_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bit_q, par_bit_d;
    logic                    par_err_q, par_err_d;
    logic                    frm_err_q, frm_err_d;
    logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    valid_q, valid_d;
    logic                    perr_out_q, perr_out_d;
    logic                    ferr_out_q, ferr_out_d;
    logic                    ovr_q, ovr_d;
    logic                    brk_q, brk_d;

    logic       rx_s, tick, mid, bit_end, maj;
    logic [1:0] vote_sum;
    logic       frame_done, frame_ferr, is_break, brk_par_ok, handshake;

    assign rx_s     = sync_q[1];
    assign tick     = (div_q == DIV_MAX);
    assign mid      = tick && (tick_cnt_q == 4'd9);
    assign bit_end  = tick && (tick_cnt_q == 4'd15);
    assign vote_sum = vote_q + {1'b0, rx_s};
    // Votes from ticks 7 and 8 plus the live tick-9 sample: two or more ones is a 1.
    assign maj      = vote_sum[1];

    always_comb begin
        sync_d     = {sync_q[0], rx_data_in};
        rx_prev_d  = rx_s;
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        vote_d     = vote_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        frame_done = 1'b0;
        frame_ferr = frm_err_q;

        if (state_q != ST_IDLE && state_q != ST_WAIT && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd7 || tick_cnt_q == 4'd8) vote_d = vote_sum;
            if (tick_cnt_q == 4'd9) vote_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d    = ST_START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                    vote_d     = '0;
                end
            end
            ST_START: begin
                if (mid && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (mid) shift_d = {maj, shift_q[WORD_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    par_bit_d = maj;
                    par_err_d = ((^shift_q) ^ maj) != ODD;
                end
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    frame_ferr = frm_err_q | ~maj;
                    frm_err_d  = frame_ferr;
                    // Finish at mid-bit so a start bit right after the stop bit is not missed.
                    if (stop_cnt_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = maj ? ST_IDLE : ST_WAIT;
                        tick_cnt_d = '0;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // tick_cnt_q counts consecutive high ticks here.
                if (tick) begin
                    if (!rx_s) tick_cnt_d = '0;
                    else if (tick_cnt_q == 4'd15) state_d = ST_IDLE;
                    else tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output holding register. Handshake: the word and flags are offered while
    // rx_data_valid is high and are consumed in any cycle where rx_ready is also high.
    always_comb begin
        handshake  = valid_q && rx_ready;
        brk_par_ok = (PARITY == 0) ? 1'b1 : ~par_bit_q;
        is_break   = (shift_q == '0) && brk_par_ok && frame_ferr;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        valid_d    = valid_q && !handshake;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;
        if (frame_done) begin
            if (is_break) begin
                brk_d = 1'b1;
            end else if (!valid_q || handshake) begin
                data_out_d = shift_q;
                perr_out_d = par_err_q;
                ferr_out_d = frame_ferr;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= '0;
            vote_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            vote_q     <= vote_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_data_out   = data_out_q;
    assign rx_data_valid = valid_q;
    assign rx_parity_err = perr_out_q;
    assign rx_frame_err  = ferr_out_q;
    assign rx_overrun    = ovr_q;
    assign rx_break      = brk_q;
    assign s_idle        = (state_q == ST_IDLE);
    assign s_start       = (state_q == ST_START);
    assign s_data        = (state_q == ST_DATA);
    assign s_parity      = (state_q == ST_PARITY);
    assign s_stop        = (state_q == ST_STOP);
    assign s_wait        = (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: an 8N1 instance and an 8E1 instance driven with serial
// frames, observed words compared against expectations built from the frame contents.
module tb_uart_rx_ovs;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic line_n = 1'b1, line_e = 1'b1;
    logic ready_n = 1'b1, ready_e = 1'b1;

    logic [7:0] data_n, data_e;
    logic valid_n, perr_n, ferr_n, ovr_n, brk_n;
    logic valid_e, perr_e, ferr_e, ovr_e, brk_e;
    logic si_n, ss_n, sd_n, sp_n, st_n, sw_n;
    logic si_e, ss_e, sd_e, sp_e, st_e, sw_e;

    uart_rx_ovs #(.CLK_RATE(6400000), .BAUD_RATE(100000), .WORD_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clock(clk), .rst(rst), .rx_data_in(line_n), .rx_data_out(data_n), .rx_data_valid(valid_n),
        .rx_ready(ready_n), .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .rx_overrun(ovr_n),
        .rx_break(brk_n), .s_idle(si_n), .s_start(ss_n), .s_data(sd_n), .s_parity(sp_n),
        .s_stop(st_n), .s_wait(sw_n)
    );

    uart_rx_ovs #(.CLK_RATE(6400000), .BAUD_RATE(100000), .WORD_WIDTH(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clock(clk), .rst(rst), .rx_data_in(line_e), .rx_data_out(data_e), .rx_data_valid(valid_e),
        .rx_ready(ready_e), .rx_parity_err(perr_e), .rx_frame_err(ferr_e), .rx_overrun(ovr_e),
        .rx_break(brk_e), .s_idle(si_e), .s_start(ss_e), .s_data(sd_e), .s_parity(sp_e),
        .s_stop(st_e), .s_wait(sw_e)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // {parity_err, frame_err, data}
    logic [9:0] exp_q[$];
    logic [9:0] got_n_q[$];
    logic [9:0] got_e_q[$];
    int ovr_n_cnt = 0, brk_n_cnt = 0, ovr_e_cnt = 0, brk_e_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_n && ready_n) got_n_q.push_back({perr_n, ferr_n, data_n});
            if (valid_e && ready_e) got_e_q.push_back({perr_e, ferr_e, data_e});
            if (ovr_n) ovr_n_cnt++;
            if (brk_n) brk_n_cnt++;
            if (ovr_e) ovr_e_cnt++;
            if (brk_e) brk_e_cnt++;
        end
    end

    task automatic drive_line(input int sel, input logic b, input int clocks);
        if (sel == 0) line_n = b;
        else line_e = b;
        repeat (clocks) @(negedge clk);
    endtask

    // Sends one frame and returns what the receiver should report for it.
    // sel 0 -> 8N1 instance, sel 1 -> 8E1 instance.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic flip_par,
                              input logic bad_stop, input int gap_bits, output logic [9:0] exp);
        logic pbit;
        logic perr;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        pbit = ((ones % 2) == 1) ^ flip_par;
        drive_line(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_line(sel, data[i], BIT_CLKS);
        if (sel != 0) drive_line(sel, pbit, BIT_CLKS);
        drive_line(sel, ~bad_stop, BIT_CLKS);
        drive_line(sel, 1'b1, gap_bits * BIT_CLKS);
        perr = (sel != 0) && (((ones + int'(pbit)) % 2) != 0);
        exp = {perr, bad_stop, data};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_n: got %h required 0", {data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n});
        end
        tests_run++;
        if ({si_n, ss_n, sd_n, sp_n, st_n, sw_n} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_state_n: got %b required 100000", {si_n, ss_n, sd_n, sp_n, st_n, sw_n});
        end
        tests_run++;
        if ({data_e, valid_e, perr_e, ferr_e, ovr_e, brk_e, si_e, ss_e, sd_e, sp_e, st_e, sw_e} !== 19'b100000) begin
            tests_failed++;
            $display("FAIL reset_all_e: got %h required 20", {data_e, valid_e, perr_e, ferr_e, ovr_e, brk_e, si_e, ss_e, sd_e, sp_e, st_e, sw_e});
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (si_n !== 1'b1 || valid_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: s_idle %b valid %b required 1 0", si_n, valid_n);
        end
    endtask

    task automatic test_basic_8n1();
        logic [9:0] e, g;
        exp_q.delete(); got_n_q.delete();
        ready_n = 1'b1;
        send_frame(0, 8'h5B, 1'b0, 1'b0, 2, e);
        exp_q.push_back(e);
        tests_run++;
        if (got_n_q.size() != 1) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d words required 1", got_n_q.size());
        end else begin
            g = got_n_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e || g !== 10'h05B) begin
                tests_failed++;
                $display("FAIL basic_word: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_random_8n1();
        logic [9:0] e, g;
        logic [7:0] d;
        logic bad;
        exp_q.delete(); got_n_q.delete();
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(1, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(0, d, 1'b0, bad, 2, e);
            exp_q.push_back(e);
        end
        tests_run++;
        if (got_n_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_n_count: got %0d words required %0d", got_n_q.size(), exp_q.size());
        end
        while (got_n_q.size() > 0 && exp_q.size() > 0) begin
            g = got_n_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL random_n_word: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_parity();
        logic [9:0] e, g;
        exp_q.delete(); got_e_q.delete();
        ready_e = 1'b1;
        send_frame(1, 8'h78, 1'b1, 1'b0, 2, e);
        exp_q.push_back(e);
        send_frame(1, 8'h78, 1'b0, 1'b0, 2, e);
        exp_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            send_frame(1, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0, 2, e);
            exp_q.push_back(e);
        end
        tests_run++;
        if (exp_q[0] !== 10'h278 || exp_q[1] !== 10'h078) begin
            tests_failed++;
            $display("FAIL parity_model: got %h %h required 278 078", exp_q[0], exp_q[1]);
        end
        tests_run++;
        if (got_e_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL parity_count: got %0d words required %0d", got_e_q.size(), exp_q.size());
        end
        while (got_e_q.size() > 0 && exp_q.size() > 0) begin
            g = got_e_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL parity_word: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic saw_start;
        saw_start = 1'b0;
        got_n_q.delete();
        line_n = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c == 20) line_n = 1'b1;
            @(negedge clk);
            if (ss_n) saw_start = 1'b1;
        end
        tests_run++;
        if (saw_start !== 1'b1 || si_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_state: saw_start %b s_idle %b required 1 1", saw_start, si_n);
        end
        repeat (4 * BIT_CLKS) @(negedge clk);
        tests_run++;
        if (got_n_q.size() != 0 || valid_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_output: got %0d words valid %b required 0 0", got_n_q.size(), valid_n);
        end
    endtask

    task automatic test_overrun();
        logic [9:0] e, g;
        int ovr0;
        exp_q.delete(); got_n_q.delete();
        ovr0 = ovr_n_cnt;
        ready_n = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, e);
        exp_q.push_back(e);
        send_frame(0, 8'h22, 1'b0, 1'b0, 2, e);
        tests_run++;
        if (valid_n !== 1'b1 || data_n !== 8'h11 || perr_n !== 1'b0 || ferr_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_hold: valid %b data %h flags %b%b required 1 11 00", valid_n, data_n, perr_n, ferr_n);
        end
        tests_run++;
        if (ovr_n_cnt - ovr0 != 1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got %0d pulses required 1", ovr_n_cnt - ovr0);
        end
        ready_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (valid_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_release: valid %b required 0", valid_n);
        end
        tests_run++;
        if (got_n_q.size() != 1) begin
            tests_failed++;
            $display("FAIL overrun_count: got %0d words required 1", got_n_q.size());
        end else begin
            g = got_n_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL overrun_word: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_break();
        int brk0;
        got_n_q.delete();
        brk0 = brk_n_cnt;
        drive_line(0, 1'b0, 12 * BIT_CLKS);
        tests_run++;
        if (sw_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_wait_low: s_wait %b required 1", sw_n);
        end
        drive_line(0, 1'b1, 50);
        tests_run++;
        if (sw_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_wait_hold: s_wait %b required 1", sw_n);
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (si_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_idle: s_idle %b required 1", si_n);
        end
        tests_run++;
        if (brk_n_cnt - brk0 != 1 || got_n_q.size() != 0) begin
            tests_failed++;
            $display("FAIL break_output: pulses %0d words %0d required 1 0", brk_n_cnt - brk0, got_n_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] e, g;
        logic [7:0] d;
        d = 8'hA5;
        got_n_q.delete(); exp_q.delete();
        ready_n = 1'b1;
        drive_line(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_line(0, d[i], BIT_CLKS);
        drive_line(0, d[3], BIT_CLKS / 2);
        tests_run++;
        if (sd_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_data: s_data %b required 1", sd_n);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, si_n, ss_n, sd_n, sp_n, st_n, sw_n} !== 19'b100000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h required 20", {data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, si_n, ss_n, sd_n, sp_n, st_n, sw_n});
        end
        line_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(0, d, 1'b0, 1'b0, 2, e);
        exp_q.push_back(e);
        tests_run++;
        if (got_n_q.size() != 1) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d words required 1", got_n_q.size());
        end else begin
            g = got_n_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e || g[7:0] !== 8'hA5) begin
                tests_failed++;
                $display("FAIL midreset_word: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e, g;
        exp_q.delete(); got_e_q.delete();
        ready_e = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_frame(1, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0, (k == 3) ? 2 : 0, e);
            exp_q.push_back(e);
        end
        tests_run++;
        if (got_e_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d words required %0d", got_e_q.size(), exp_q.size());
        end
        while (got_e_q.size() > 0 && exp_q.size() > 0) begin
            g = got_e_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL b2b_word: got %h required %h", g, e);
            end
        end
        tests_run++;
        if (ovr_e_cnt != 0 || brk_e_cnt != 0) begin
            tests_failed++;
            $display("FAIL b2b_pulses: overrun %0d break %0d required 0 0", ovr_e_cnt, brk_e_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_random_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_RATE, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter WORD_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-006 SHALL have a port clock, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have a port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-008 SHALL have a port rx_data_in, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have a port rx_data_out, output, WORD_WIDTH bits, received word, LSB first on the line.
REQ-010 SHALL have a port rx_data_valid, output, 1 bit, word and error flags held valid.
REQ-011 SHALL have a port rx_ready, input, 1 bit, consumer accepts the word.
REQ-012 SHALL have a port rx_parity_err, output, 1 bit, parity mismatch; qualified by rx_data_valid.
REQ-013 SHALL have a port rx_frame_err, output, 1 bit, a stop bit sampled low; qualified by rx_data_valid.
REQ-014 SHALL have a port rx_overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have a port rx_break, output, 1 bit, one-cycle pulse on break detection.
REQ-016 SHALL have ports s_idle, s_start, s_data, s_parity, s_stop and s_wait, outputs, 1 bit each, one-hot FSM state indicators.

Function
REQ-017 SHALL pass rx_data_in through a 2-flop synchronizer, reset value 1, before any use.
REQ-018 SHALL generate a one-cycle tick every TICK_DIV = CLK_RATE/(BAUD_RATE*16) clocks (integer division), i.e. 16 ticks per bit; the tick counter free-runs and restarts at 0 on entry to START.
REQ-019 SHALL sample each bit by majority vote of the synchronized line at ticks 7, 8 and 9 of that bit.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP and WAIT; s_* reflect the current state.
REQ-021 IDLE -> START on a synchronized falling edge.
REQ-022 START: a majority of 1 at mid-bit SHALL count as a false start and return the FSM to IDLE with no output; a majority of 0 SHALL move the FSM to DATA at bit end.
REQ-023 DATA: the FSM SHALL shift WORD_WIDTH bits LSB first, then go to PARITY when PARITY != 0, else to STOP.
REQ-024 PARITY: odd mode SHALL expect the XOR of data and the parity bit to be 1; even mode SHALL expect 0; a mismatch SHALL set the pending parity_err.
REQ-025 STOP: the FSM SHALL sample STOP_BITS stop bits; any low sample SHALL set the pending frame_err.
REQ-026 At the mid-point of the last stop bit the FSM SHALL complete the frame and go to IDLE, or go to WAIT if the line is low; the FSM SHALL NOT wait for the stop-bit end.
REQ-027 WAIT: the FSM SHALL stay until the synchronized line is 1 for 16 consecutive ticks, then go to IDLE.
REQ-028 Break: data all zero, parity bit (if present) 0 and frame_err set SHALL produce an rx_break pulse instead of a word; rx_data_valid SHALL NOT assert for that frame.
REQ-029 Frame completion with rx_data_valid low SHALL load rx_data_out and both error flags and set rx_data_valid in the next cycle.
REQ-030 rx_data_valid SHALL stay high and rx_data_out and the error flags SHALL stay stable until a cycle where rx_data_valid and rx_ready are both high; rx_data_valid SHALL clear on the following edge.
REQ-031 Frame completion while rx_data_valid is high and rx_ready is low SHALL drop the new word, pulse rx_overrun and leave the held word intact.
REQ-032 Frame completion in the same cycle as a valid and ready handshake SHALL load the new word and keep rx_data_valid high; this is not an overrun.
REQ-033 rx_ready SHALL be ignored while rx_data_valid is low.

Reset
REQ-034 While rst is high the FSM SHALL be in IDLE, s_idle SHALL be 1 and all other s_* SHALL be 0.
REQ-035 While rst is high, rx_data_out SHALL be 0; rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun and rx_break SHALL be 0; the tick counter and synchronizer SHALL be at their reset values.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no output.
REQ-037 After reset release the next falling edge SHALL start a new frame.

Verification (CLK_RATE=6400000, BAUD_RATE=100000, so TICK_DIV=4 and 64 clocks per bit)
REQ-038 Frame 0x5B in 8N1 with rx_ready=1 -> one rx_data_valid with rx_data_out=0x5B and both error flags 0.
REQ-039 PARITY=2: frame 0x78 with a wrong parity bit -> rx_data_out=0x78 and rx_parity_err=1; a correct parity bit -> rx_parity_err=0.
REQ-040 A 20-clock low glitch on an idle line -> no rx_data_valid and the FSM back in s_idle within 64 clocks.
REQ-041 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data_out stays 0x11 and rx_overrun pulses once; asserting rx_ready afterwards -> the valid handshake clears rx_data_valid.
REQ-042 Line held low for 12 bit times -> rx_break pulses once, no rx_data_valid, s_wait holds until the line is high for 16 ticks.
REQ-043 rst asserted during DATA bit 3 -> all outputs are at reset values immediately; the next frame 0xA5 is received correctly.
